// File: rtl/esl_sto_output_ctrl_if.sv
// Signal bundle of the STO output controller: decoded powerdown pairs and supply
// feedback in, PWM inhibit / gate-driver supply enables and diagnostics out.
interface esl_sto_output_ctrl_if;
   logic       pd_p;
   logic       pd_n;
   logic       pd_dup_p;
   logic       pd_dup_n;
   logic       sto_fb_a;
   logic       sto_fb_b;
   logic       pwm_inhibit;
   logic       sto_en_a;
   logic       sto_en_b;
   logic       sto_active;
   logic       discrepancy_fault;
   logic       feedback_fault;
   logic [2:0] state;

   modport master (
      output pd_p, pd_n, pd_dup_p, pd_dup_n, sto_fb_a, sto_fb_b,
      input  pwm_inhibit, sto_en_a, sto_en_b, sto_active,
             discrepancy_fault, feedback_fault, state
   );

   modport slave (
      input  pd_p, pd_n, pd_dup_p, pd_dup_n, sto_fb_a, sto_fb_b,
      output pwm_inhibit, sto_en_a, sto_en_b, sto_active,
             discrepancy_fault, feedback_fault, state
   );
endinterface

// File: rtl/esl_sto_output_ctrl.sv
// Safe Torque Off sequencer: decodes both powerdown channels, inhibits PWM, then
// removes both gate-driver supplies, supervising supply feedback; safe state latches.
module esl_sto_output_ctrl #(
   parameter int P_ESL_CLK_FREQ_HZ = 20_000_000,
   parameter int P_STOP_DELAY_US   = 5,
   parameter int P_DISCREPANCY_US  = 10,
   parameter int P_FB_TIMEOUT_US   = 100
) (
   input  logic                 esl_clk,
   input  logic                 esl_reset,
   esl_sto_output_ctrl_if.slave bus
);
   localparam int CYC_PER_US = P_ESL_CLK_FREQ_HZ / 1_000_000;
   localparam int STOP_CNT   = CYC_PER_US * P_STOP_DELAY_US;
   localparam int DISC_CNT   = CYC_PER_US * P_DISCREPANCY_US;
   localparam int FB_CNT     = CYC_PER_US * P_FB_TIMEOUT_US;
   localparam int TMR_MAX    = (FB_CNT > STOP_CNT) ? FB_CNT : STOP_CNT;
   localparam int TMR_W      = $clog2(TMR_MAX + 1);
   localparam int DISC_W     = $clog2(DISC_CNT + 1);

   localparam logic [TMR_W-1:0]  STOP_LAST = TMR_W'(STOP_CNT - 1);
   localparam logic [TMR_W-1:0]  FB_LAST   = TMR_W'(FB_CNT - 1);
   localparam logic [TMR_W-1:0]  FB_FULL   = TMR_W'(FB_CNT);
   localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISC_CNT - 1);
   localparam logic [DISC_W-1:0] DISC_FULL = DISC_W'(DISC_CNT);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_RUN     = 3'd1,
      S_INHIBIT = 3'd2,
      S_STO     = 3'd3,
      S_SAFE    = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   typedef struct packed {
      logic inhibit;
      logic en_a;
      logic en_b;
      logic active;
   } drive_t;

   // Output levels held while resident in each state; only INIT->RUN enables supply.
   function automatic drive_t drive_of(state_t s);
      case (s)
         S_RUN:     return '{inhibit: 1'b0, en_a: 1'b1, en_b: 1'b1, active: 1'b0};
         S_INHIBIT: return '{inhibit: 1'b1, en_a: 1'b1, en_b: 1'b1, active: 1'b0};
         default:   return '{inhibit: 1'b1, en_a: 1'b0, en_b: 1'b0, active: 1'b1};
      endcase
   endfunction

   logic [2:0] rst_pipe;
   logic       rst_sync_n;

   // NOTE: all sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge esl_clk or negedge esl_reset) begin
      if (!esl_reset) rst_pipe <= '0;
      else            rst_pipe <= {rst_pipe[1:0], 1'b1};
   end
   assign rst_sync_n = rst_pipe[2];

   logic fb_a_meta, fb_b_meta, fb_a_s, fb_b_s;

   // NOTE: feedback resets to "supply present" so INIT cannot leave before real feedback arrives.
   always_ff @(posedge esl_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         {fb_a_meta, fb_a_s} <= 2'b11;
         {fb_b_meta, fb_b_s} <= 2'b11;
      end else begin
         {fb_a_meta, fb_a_s} <= {bus.sto_fb_a, fb_a_meta};
         {fb_b_meta, fb_b_s} <= {bus.sto_fb_b, fb_b_meta};
      end
   end

   logic req_a, req_b, req_any, fb_any, fb_all;
   assign req_a   = ~(~bus.pd_p     & bus.pd_n);
   assign req_b   = ~(~bus.pd_dup_p & bus.pd_dup_n);
   assign req_any = req_a | req_b;
   assign fb_any  = fb_a_s | fb_b_s;
   assign fb_all  = fb_a_s & fb_b_s;

   logic [DISC_W-1:0] disc_cnt;
   logic              discrepancy_fault_q;

   always_ff @(posedge esl_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         disc_cnt            <= '0;
         discrepancy_fault_q <= 1'b0;
      end else if (req_a != req_b) begin
         if (disc_cnt != DISC_FULL) disc_cnt <= disc_cnt + 1'b1;
         if (disc_cnt == DISC_LAST) discrepancy_fault_q <= 1'b1;
      end else begin
         disc_cnt <= '0;
      end
   end

   state_t           state;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] age;
   logic             pwm_inhibit_q, sto_active_q, feedback_fault_q;
   (* preserve *) logic sto_en_a_q;
   (* preserve *) logic sto_en_b_q;

   always_ff @(posedge esl_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state            <= S_INIT;
         {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_INIT);
         feedback_fault_q <= 1'b0;
         tmr              <= '0;
         age              <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (fb_any && tmr == FB_LAST) begin
                  state            <= S_FAULT;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_FAULT);
                  feedback_fault_q <= 1'b1;
               end else if (!fb_any && !req_any && !discrepancy_fault_q) begin
                  state <= S_RUN;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_RUN);
                  tmr   <= '0;
                  age   <= '0;
               end else begin
                  tmr <= fb_any ? tmr + 1'b1 : '0;
               end
            end
            S_RUN: begin
               if (req_any || discrepancy_fault_q) begin
                  state <= S_INHIBIT;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_INHIBIT);
                  tmr   <= '0;
               end else if (!fb_all && tmr == FB_LAST) begin
                  state            <= S_FAULT;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_FAULT);
                  feedback_fault_q <= 1'b1;
               end else begin
                  // Feedback glitches inside the power-up window accumulate instead of clearing.
                  if (!fb_all)             tmr <= tmr + 1'b1;
                  else if (age == FB_FULL) tmr <= '0;
                  if (age != FB_FULL)      age <= age + 1'b1;
               end
            end
            S_INHIBIT: begin
               if (tmr == STOP_LAST) begin
                  state <= S_STO;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_STO);
                  tmr   <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_STO: begin
               if (tmr == FB_LAST) begin
                  state            <= S_FAULT;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_FAULT);
                  feedback_fault_q <= 1'b1;
               end else if (!fb_any) begin
                  state <= S_SAFE;
                  {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_SAFE);
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_SAFE, S_FAULT: ;
            default: begin
               state            <= S_FAULT;
               {pwm_inhibit_q, sto_en_a_q, sto_en_b_q, sto_active_q} <= drive_of(S_FAULT);
               feedback_fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.pwm_inhibit       = pwm_inhibit_q;
   assign bus.sto_en_a          = sto_en_a_q;
   assign bus.sto_en_b          = sto_en_b_q;
   assign bus.sto_active        = sto_active_q;
   assign bus.discrepancy_fault = discrepancy_fault_q;
   assign bus.feedback_fault    = feedback_fault_q;
   assign bus.state             = state;
endmodule

// File: tb/tb_esl_sto_output_ctrl.sv
// Self-checking bench for esl_sto_output_ctrl: randomized channel codes and timing,
// expectations derived from the decode rule, state output table and cycle budgets.
module tb_esl_sto_output_ctrl;
   localparam int FREQ     = 20_000_000;
   localparam int STOP_US  = 5;
   localparam int DISC_US  = 10;
   localparam int FB_US    = 100;
   localparam int CPU      = FREQ / 1_000_000;
   localparam int STOP_CNT = CPU * STOP_US;
   localparam int DISC_CNT = CPU * DISC_US;
   localparam int FB_CNT   = CPU * FB_US;
   localparam int RST_LAT  = 3;
   localparam int FB_LAT   = 2;

   localparam logic [2:0] ST_INIT = 3'd0, ST_RUN = 3'd1, ST_INHIBIT = 3'd2,
                          ST_STO  = 3'd3, ST_SAFE = 3'd4, ST_FAULT = 3'd5;

   logic esl_clk   = 1'b0;
   logic esl_reset = 1'b0;
   int   n_cmp     = 0;
   int   n_err     = 0;

   esl_sto_output_ctrl_if bus ();

   esl_sto_output_ctrl #(
      .P_ESL_CLK_FREQ_HZ(FREQ),
      .P_STOP_DELAY_US  (STOP_US),
      .P_DISCREPANCY_US (DISC_US),
      .P_FB_TIMEOUT_US  (FB_US)
   ) dut (
      .esl_clk  (esl_clk),
      .esl_reset(esl_reset),
      .bus      (bus)
   );

   always #25 esl_clk = ~esl_clk;

   initial begin
      #(50 * 90_000);
      $display("FAIL watchdog: simulation exceeded 90000 cycles, want completion");
      $fatal(1);
   end

   // Channel request rule: anything except exactly 01 asks for powerdown.
   function automatic logic req_of(logic [1:0] code);
      return code != 2'b01;
   endfunction

   // Expected {inhibit, en_a, en_b, active} per state.
   function automatic logic [3:0] outs_for(logic [2:0] st);
      case (st)
         ST_RUN:     return 4'b0110;
         ST_INHIBIT: return 4'b1110;
         default:    return 4'b1001;
      endcase
   endfunction

   function automatic logic [8:0] want(logic [2:0] st, logic disc, logic fbf);
      return {st, outs_for(st), disc, fbf};
   endfunction

   function automatic logic [8:0] snap();
      return {bus.state, bus.pwm_inhibit, bus.sto_en_a, bus.sto_en_b, bus.sto_active,
              bus.discrepancy_fault, bus.feedback_fault};
   endfunction

   function automatic logic [1:0] rand_req_code();
      case ($urandom_range(2))
         0:       return 2'b10;
         1:       return 2'b00;
         default: return 2'b11;
      endcase
   endfunction

   task automatic tick(int n);
      repeat (n) @(negedge esl_clk);
   endtask

   task automatic set_pd(logic [1:0] a, logic [1:0] b);
      bus.pd_p     = a[1];
      bus.pd_n     = a[0];
      bus.pd_dup_p = b[1];
      bus.pd_dup_n = b[0];
   endtask

   task automatic bring_up();
      int i;
      esl_reset = 1'b0;
      set_pd(2'b01, 2'b01);
      bus.sto_fb_a = 1'b0;
      bus.sto_fb_b = 1'b0;
      tick(2);
      esl_reset = 1'b1;
      i = 0;
      while (i < 20 && bus.state !== ST_RUN) begin
         tick(1);
         i++;
      end
      n_cmp++;
      if (bus.state !== ST_RUN) begin
         n_err++;
         $display("FAIL bring_up: state=%0d after 20 cycles, want %0d", bus.state, ST_RUN);
      end
   endtask

   task automatic test_reset();
      logic [8:0] w;
      int i;
      esl_reset = 1'b0;
      set_pd(2'b01, 2'b01);
      bus.sto_fb_a = 1'b0;
      bus.sto_fb_b = 1'b0;
      tick(2);
      n_cmp++; w = want(ST_INIT, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL reset_values: got %b want %b", snap(), w); end
      esl_reset = 1'b1;
      tick(RST_LAT);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL reset_sync_hold: got %b want %b", snap(), w); end
      i = 0;
      while (i < FB_LAT + 3 && bus.state !== ST_RUN) begin
         tick(1);
         i++;
      end
      n_cmp++; w = want(ST_RUN, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL run_entry: got %b want %b", snap(), w); end
      tick($urandom_range(190, 1));
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(FB_CNT + 100);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL run_fb_up: got %b want %b", snap(), w); end
   endtask

   task automatic test_decode();
      logic [8:0] w;
      logic [1:0] a, b;
      logic       req;
      for (int it = 0; it < 8; it++) begin
         bring_up();
         bus.sto_fb_a = 1'b1;
         bus.sto_fb_b = 1'b1;
         tick(3);
         a = (it == 0) ? 2'b01 : 2'($urandom_range(3));
         b = (it == 0) ? 2'b01 : 2'($urandom_range(3));
         req = req_of(a) | req_of(b);
         set_pd(a, b);
         tick(1);
         n_cmp++; w = want(req ? ST_INHIBIT : ST_RUN, 1'b0, 1'b0);
         if (snap() !== w) begin
            n_err++;
            $display("FAIL decode a=%b b=%b: got %b want %b", a, b, snap(), w);
         end
         if (!req) begin
            tick(20);
            n_cmp++;
            if (snap() !== w) begin n_err++; $display("FAIL decode_idle: got %b want %b", snap(), w); end
         end
      end
   endtask

   task automatic test_stop_sequence();
      logic [8:0] w;
      bring_up();
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick($urandom_range(50, 5));
      set_pd(rand_req_code(), rand_req_code());
      tick(1);
      n_cmp++; w = want(ST_INHIBIT, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL stop_inhibit: got %b want %b", snap(), w); end
      set_pd(2'b01, 2'b01);
      tick(STOP_CNT - 1);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL stop_en_held: got %b want %b", snap(), w); end
      tick(1);
      n_cmp++; w = want(ST_STO, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL stop_en_off: got %b want %b", snap(), w); end
      tick(20);
      bus.sto_fb_a = 1'b0;
      bus.sto_fb_b = 1'b0;
      tick(FB_LAT);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL sto_fb_latency: got %b want %b", snap(), w); end
      tick(1);
      n_cmp++; w = want(ST_SAFE, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL safe_entry: got %b want %b", snap(), w); end
      set_pd(2'b01, 2'b01);
      tick(50);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL safe_latched: got %b want %b", snap(), w); end
   endtask

   task automatic test_discrepancy();
      logic [8:0] w;
      logic       on_b;
      logic [1:0] code;
      bring_up();
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(5);
      on_b = 1'($urandom_range(1));
      code = rand_req_code();
      if (on_b) set_pd(2'b01, code);
      else      set_pd(code, 2'b01);
      tick(1);
      n_cmp++; w = want(ST_INHIBIT, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL disc_inhibit: got %b want %b", snap(), w); end
      tick(DISC_CNT - 2);
      n_cmp++; w = want(ST_STO, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL disc_before: got %b want %b", snap(), w); end
      tick(1);
      n_cmp++; w = want(ST_STO, 1'b1, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL disc_set: got %b want %b", snap(), w); end
      tick(50);
      set_pd(2'b01, 2'b01);
      tick(50);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL disc_sticky: got %b want %b", snap(), w); end
   endtask

   task automatic test_sto_fb_timeout();
      logic [8:0] w;
      bring_up();
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(5);
      set_pd(2'b10, 2'b10);
      bus.sto_fb_b = 1'($urandom_range(1));
      tick(STOP_CNT + 1);
      n_cmp++; w = want(ST_STO, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL sto_entry: got %b want %b", snap(), w); end
      tick(FB_CNT - 1);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL sto_before_timeout: got %b want %b", snap(), w); end
      tick(1);
      n_cmp++; w = want(ST_FAULT, 1'b0, 1'b1);
      if (snap() !== w) begin n_err++; $display("FAIL sto_timeout: got %b want %b", snap(), w); end
   endtask

   task automatic test_run_fb_drop();
      logic [8:0] w;
      logic       drop_b;
      bring_up();
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(FB_CNT + 50);
      drop_b = 1'($urandom_range(1));
      if (drop_b) bus.sto_fb_b = 1'b0; else bus.sto_fb_a = 1'b0;
      tick(FB_CNT - 1);
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(30);
      n_cmp++; w = want(ST_RUN, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL run_drop_short: got %b want %b", snap(), w); end
      if (drop_b) bus.sto_fb_b = 1'b0; else bus.sto_fb_a = 1'b0;
      tick(FB_CNT);
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(1);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL run_drop_edge: got %b want %b", snap(), w); end
      tick(1);
      n_cmp++; w = want(ST_FAULT, 1'b0, 1'b1);
      if (snap() !== w) begin n_err++; $display("FAIL run_drop_fault: got %b want %b", snap(), w); end
   endtask

   task automatic test_reset_mid();
      logic [8:0] w;
      bring_up();
      bus.sto_fb_a = 1'b1;
      bus.sto_fb_b = 1'b1;
      tick(5);
      set_pd(rand_req_code(), rand_req_code());
      tick($urandom_range(STOP_CNT - 10, 10));
      n_cmp++; w = want(ST_INHIBIT, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL mid_inhibit: got %b want %b", snap(), w); end
      #5 esl_reset = 1'b0;
      #1;
      n_cmp++; w = want(ST_INIT, 1'b0, 1'b0);
      if (snap() !== w) begin n_err++; $display("FAIL async_reset: got %b want %b", snap(), w); end
      tick(3);
      esl_reset = 1'b1;
      tick(RST_LAT + FB_CNT - 1);
      n_cmp++;
      if (snap() !== w) begin n_err++; $display("FAIL init_hold: got %b want %b", snap(), w); end
      tick(1);
      n_cmp++; w = want(ST_FAULT, 1'b0, 1'b1);
      if (snap() !== w) begin n_err++; $display("FAIL init_timeout: got %b want %b", snap(), w); end
   endtask

   initial begin
      set_pd(2'b01, 2'b01);
      bus.sto_fb_a = 1'b0;
      bus.sto_fb_b = 1'b0;
      tick(1);
      test_reset();
      test_decode();
      test_stop_sequence();
      test_discrepancy();
      test_sto_fb_timeout();
      test_run_fb_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/esl_sto_output_ctrl.md
Name: esl_sto_output_ctrl

Overview:
Downstream consumer of the safety decision block's dual complementary powerdown outputs (motor_powerdown_p/n and motor_powerdown_dup_p/n). It decodes both channels and sequences a Safe Torque Off: PWM inhibit first, then removal of both gate-driver supply enables. It monitors external supply feedback for plausibility and latches the safe state until reset. Lives in the ESL clock domain next to the safety decision block; its outputs drive the inverter gate-driver enables.

Parameters:
P_ESL_CLK_FREQ_HZ, 20_000_000, esl_clk frequency
P_STOP_DELAY_US, 5, PWM-inhibit to supply-removal delay
P_DISCREPANCY_US, 10, max tolerated disagreement between decoded channels A and B
P_FB_TIMEOUT_US, 100, max time for feedback to follow sto_en_a/b

Ports:
esl_clk  in  1  ESL clock
esl_reset  in  1  reset, asynchronous, active-low
pd_p, pd_n  in  1 each  channel A powerdown pair, synchronous to esl_clk; valid request = 10
pd_dup_p, pd_dup_n  in  1 each  channel B duplicate pair, same encoding
sto_fb_a, sto_fb_b  in  1 each  external supply-present feedback, asynchronous; 1 = supply on
pwm_inhibit  out  1  1 = PWM gating blocked
sto_en_a, sto_en_b  out  1 each  gate-driver supply enables; 1 = powered
sto_active  out  1  1 in STO, SAFE or FAULT
discrepancy_fault  out  1  sticky flag
feedback_fault  out  1  sticky flag
state  out  3  encoded FSM state for diagnostics

Behaviour:
- Counter constants:
  - STOP_CNT = FREQ/1e6*P_STOP_DELAY_US = 100 at defaults.
  - DISC_CNT = 200.
  - FB_CNT = 2000.
  - Counter widths are $clog2(max+1).
- Reset values, asserted asynchronously and released synchronously by a 3-flop reset synchroniser:
  - pwm_inhibit=1, sto_en_a=sto_en_b=0, sto_active=1.
  - Both fault flags 0. state=INIT.
- Feedback: sto_fb_a/b pass through a 2-flop synchroniser to give fb_a_s/fb_b_s (2-cycle latency).
- Channel decode, per pair:
  - req = 1 unless the pair is exactly 01.
  - So 10 means request; 00/11 are invalid and also mean request (fail-safe).
  - req_any = reqA | reqB.
- Discrepancy check:
  - Counter increments while reqA != reqB and clears when they are equal.
  - When count reaches DISC_CNT, discrepancy_fault is set (sticky) and the FSM is forced toward SAFE.
- FSM encodings: INIT=0, RUN=1, INHIBIT=2, STO=3, SAFE=4, FAULT=5.
- INIT:
  - Outputs: inhibit=1, en=0.
  - Wait until fb_a_s=fb_b_s=0 and req_any=0, then go to RUN.
  - If feedback is still 1 after FB_CNT cycles, go to FAULT.
- RUN:
  - Outputs: inhibit=0, en=1.
  - On req_any=1 or discrepancy_fault, go to INHIBIT. pwm_inhibit is registered to 1 on the cycle after req_any is sampled.
  - Feedback supervision in RUN:
    - A counter starts on entry and runs while either fb_x_s=0.
    - The counter clears once both are 1, but only after the first FB_CNT window.
    - If it reaches FB_CNT, go to FAULT.
- INHIBIT:
  - Outputs: inhibit=1, en=1.
  - Count STOP_CNT cycles, then go to STO.
  - A request that clears during INHIBIT does not return to RUN.
- STO:
  - Outputs: inhibit=1, en=0.
  - When both fb_x_s=0, go to SAFE.
  - If FB_CNT elapses first, go to FAULT.
- SAFE:
  - Terminal; left only via reset. Outputs as in STO.
- FAULT:
  - Terminal. Outputs as in STO.
  - feedback_fault=1, set on entry.
- Simultaneous events: a feedback timeout and completion on the same cycle resolve to FAULT. Reset mid-sequence immediately forces reset values; supply never re-enables without passing through INIT.
- sto_en_a and sto_en_b are separate registers with the (* preserve *) attribute and are never merged.
- Outputs are registered. No output transitions from safe to unsafe except INIT→RUN.

Test Plan:
1. Reset release, pd=01/01, fb=0 → enter RUN; en=1, inhibit=0. Drive fb=1 within 10 µs → stays in RUN with no fault.
2. In RUN, drive pd=10 on both channels at cycle N:
   - pwm_inhibit=1 at N+1.
   - sto_en=0 at N+101.
   - fb→0 after 20 cycles → SAFE; state=4.
   - Then drive pd=01 → remains SAFE.
3. In RUN, set only channel B to 11 for 250 cycles:
   - Immediate INHIBIT/STO sequence.
   - discrepancy_fault=1 at +200 cycles and stays set after B returns to 01.
4. In STO, hold fb_a=1 → FAULT at 2000 cycles after STO entry; feedback_fault=1, en stays 0.
5. In RUN, drop fb_b to 0 for 2000 cycles → FAULT. A drop of 1999 cycles causes no fault.
6. Assert esl_reset in the middle of INHIBIT → all outputs take reset values asynchronously. After release with fb=1 held, the block stays in INIT and reaches FAULT after 2000 cycles.
